// File: rtl/axis_iter_divider_if.sv
// axis_iter_divider_if
// Purpose: groups the divider's AXI-stream channels into one bundle: two operand
// channels into the divider and one result channel out of it.
// Signals:
//   s_axis_dividend_tvalid/tready/tdata : dividend operand channel
//   s_axis_divisor_tvalid/tready/tdata  : divisor operand channel
//   m_axis_dout_tvalid                  : one-cycle result pulse, no backpressure
//   m_axis_dout_tdata                   : {quotient, remainder}
//   m_axis_dout_tuser                   : divide-by-zero flag, qualified by tvalid
// Modports:
//   slave  : the divider side
//   master : the requester side (execute stage or testbench)
interface axis_iter_divider_if #(
  parameter int WIDTH = 32
);
  logic               s_axis_dividend_tvalid;
  logic               s_axis_dividend_tready;
  logic [WIDTH-1:0]   s_axis_dividend_tdata;
  logic               s_axis_divisor_tvalid;
  logic               s_axis_divisor_tready;
  logic [WIDTH-1:0]   s_axis_divisor_tdata;
  logic               m_axis_dout_tvalid;
  logic [2*WIDTH-1:0] m_axis_dout_tdata;
  logic               m_axis_dout_tuser;

  modport slave (
    input  s_axis_dividend_tvalid,
    output s_axis_dividend_tready,
    input  s_axis_dividend_tdata,
    input  s_axis_divisor_tvalid,
    output s_axis_divisor_tready,
    input  s_axis_divisor_tdata,
    output m_axis_dout_tvalid,
    output m_axis_dout_tdata,
    output m_axis_dout_tuser
  );

  modport master (
    output s_axis_dividend_tvalid,
    input  s_axis_dividend_tready,
    output s_axis_dividend_tdata,
    output s_axis_divisor_tvalid,
    input  s_axis_divisor_tready,
    output s_axis_divisor_tdata,
    input  m_axis_dout_tvalid,
    input  m_axis_dout_tdata,
    input  m_axis_dout_tuser
  );
endinterface

// File: rtl/axis_iter_divider.sv
// axis_iter_divider
// Purpose: multi-cycle radix-2 restoring divider with an AXI-stream divider
// interface. One quotient bit is produced per clock; the result is
// {quotient, remainder} with truncation toward zero when SIGNED=1.
// Parameters:
//   WIDTH  : operand width in bits
//   SIGNED : 1 = two's-complement division, 0 = unsigned division
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   axis : axis_iter_divider_if.slave (dividend/divisor channels in, result out)
module axis_iter_divider #(
  parameter int WIDTH  = 32,
  parameter int SIGNED = 1
) (
  input logic                clk,
  input logic                rst,
  axis_iter_divider_if.slave axis
);

  localparam int            CW        = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);
  localparam bit            IS_SIGNED = (SIGNED != 0);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic             dividend_captured;
  logic             divisor_captured;
  logic [WIDTH-1:0] dividend_hold;
  logic [WIDTH-1:0] divisor_hold;

  // quo starts out holding the dividend magnitude and fills with quotient bits
  // as the dividend bits are shifted out into rem.
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH:0]   divisor_mag;
  logic [WIDTH-1:0] dividend_orig;
  logic             quo_neg;
  logic             rem_neg;
  logic             div_zero;
  logic [CW-1:0]    iter;

  logic             dividend_fire;
  logic             divisor_fire;
  logic             start;
  logic [WIDTH-1:0] dividend_op;
  logic [WIDTH-1:0] divisor_op;
  logic             dividend_neg;
  logic             divisor_neg;
  logic [WIDTH-1:0] dividend_abs;
  logic [WIDTH-1:0] divisor_abs;

  logic [WIDTH:0]   rem_shift;
  logic             no_borrow;
  logic [WIDTH-1:0] rem_diff;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] quo_final;
  logic [WIDTH-1:0] rem_final;

  assign axis.s_axis_dividend_tready = !rst && (state != BUSY) && !dividend_captured;
  assign axis.s_axis_divisor_tready  = !rst && (state != BUSY) && !divisor_captured;

  assign dividend_fire = axis.s_axis_dividend_tvalid && axis.s_axis_dividend_tready;
  assign divisor_fire  = axis.s_axis_divisor_tvalid && axis.s_axis_divisor_tready;

  // An operation starts on the edge that completes the operand pair, whether the
  // missing operand arrives now or both arrive together.
  assign start = (state != BUSY)
              && (dividend_captured || dividend_fire)
              && (divisor_captured || divisor_fire);

  assign dividend_op = dividend_captured ? dividend_hold : axis.s_axis_dividend_tdata;
  assign divisor_op  = divisor_captured ? divisor_hold : axis.s_axis_divisor_tdata;

  assign dividend_neg = IS_SIGNED && dividend_op[WIDTH-1];
  assign divisor_neg  = IS_SIGNED && divisor_op[WIDTH-1];

  // Negating the most negative value wraps back to itself, which read as an
  // unsigned number is exactly its magnitude.
  assign dividend_abs = dividend_neg ? -dividend_op : dividend_op;
  assign divisor_abs  = divisor_neg ? -divisor_op : divisor_op;

  // rem is always below the divisor, so after the shift the remainder fits in
  // WIDTH+1 bits and the kept difference fits back into WIDTH bits.
  assign rem_shift = {rem, quo[WIDTH-1]};
  assign no_borrow = (rem_shift >= divisor_mag);
  assign rem_diff  = rem_shift[WIDTH-1:0] - divisor_mag[WIDTH-1:0];
  assign rem_next  = no_borrow ? rem_diff : rem_shift[WIDTH-1:0];
  assign quo_next  = {quo[WIDTH-2:0], no_borrow};

  // Divide by zero reports the untouched dividend rather than its magnitude.
  assign quo_final = div_zero ? {WIDTH{1'b1}} : (quo_neg ? -quo_next : quo_next);
  assign rem_final = div_zero ? dividend_orig : (rem_neg ? -rem_next : rem_next);

  always_ff @(posedge clk) begin
    if (rst) begin
      state                   <= IDLE;
      dividend_captured       <= 1'b0;
      divisor_captured        <= 1'b0;
      iter                    <= '0;
      axis.m_axis_dout_tvalid <= 1'b0;
      axis.m_axis_dout_tdata  <= '0;
      axis.m_axis_dout_tuser  <= 1'b0;
    end else begin
      axis.m_axis_dout_tvalid <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            dividend_captured <= 1'b0;
            divisor_captured  <= 1'b0;
            quo               <= dividend_abs;
            rem               <= '0;
            divisor_mag       <= {1'b0, divisor_abs};
            dividend_orig     <= dividend_op;
            quo_neg           <= dividend_neg ^ divisor_neg;
            rem_neg           <= dividend_neg;
            div_zero          <= (divisor_op == '0);
            iter              <= '0;
            state             <= BUSY;
          end else begin
            if (dividend_fire) begin
              dividend_captured <= 1'b1;
              dividend_hold     <= axis.s_axis_dividend_tdata;
            end
            if (divisor_fire) begin
              divisor_captured <= 1'b1;
              divisor_hold     <= axis.s_axis_divisor_tdata;
            end
            state <= IDLE;
          end
        end
        BUSY: begin
          rem  <= rem_next;
          quo  <= quo_next;
          iter <= iter + CW'(1);
          if (iter == LAST_ITER) begin
            state                   <= DONE;
            axis.m_axis_dout_tvalid <= 1'b1;
            axis.m_axis_dout_tdata  <= {quo_final, rem_final};
            axis.m_axis_dout_tuser  <= div_zero;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_iter_divider.sv
// tb_axis_iter_divider
// Purpose: self-checking bench for axis_iter_divider. An unsigned and a signed
// instance run side by side from a table of directed vectors, followed by
// hand-written sequences for staggered operands, back-to-back operations and
// reset in the middle of a division.
// Ports: none (top-level bench).
module tb_axis_iter_divider;

  localparam int W      = 32;
  localparam int LAT    = W + 1;
  localparam int BUDGET = 80;
  localparam int NVEC   = 12;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] exp_u;
    logic           user_u;
    logic [2*W-1:0] exp_s;
    logic           user_s;
  } vec_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  int   pulses_u;
  int   pulses_s;
  vec_t vecs [NVEC];

  axis_iter_divider_if #(.WIDTH(W)) if_u ();
  axis_iter_divider_if #(.WIDTH(W)) if_s ();

  axis_iter_divider #(.WIDTH(W), .SIGNED(0)) dut_u (
    .clk  (clk),
    .rst  (rst),
    .axis (if_u)
  );

  axis_iter_divider #(.WIDTH(W), .SIGNED(1)) dut_s (
    .clk  (clk),
    .rst  (rst),
    .axis (if_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts result pulses of each instance, sampled on the inactive edge.
  always @(negedge clk) begin
    if (if_u.m_axis_dout_tvalid) pulses_u++;
    if (if_s.m_axis_dout_tvalid) pulses_s++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input logic [2*W-1:0] actual,
                              input logic [2*W-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
    end
  endtask

  task automatic idle_inputs();
    if_u.s_axis_dividend_tvalid = 1'b0;
    if_u.s_axis_dividend_tdata  = '0;
    if_u.s_axis_divisor_tvalid  = 1'b0;
    if_u.s_axis_divisor_tdata   = '0;
    if_s.s_axis_dividend_tvalid = 1'b0;
    if_s.s_axis_dividend_tdata  = '0;
    if_s.s_axis_divisor_tvalid  = 1'b0;
    if_s.s_axis_divisor_tdata   = '0;
  endtask

  task automatic apply_stimulus(input bit on_u, input bit on_s,
                                input logic [W-1:0] a, input logic [W-1:0] b);
    if (on_u) begin
      if_u.s_axis_dividend_tvalid = 1'b1;
      if_u.s_axis_dividend_tdata  = a;
      if_u.s_axis_divisor_tvalid  = 1'b1;
      if_u.s_axis_divisor_tdata   = b;
    end
    if (on_s) begin
      if_s.s_axis_dividend_tvalid = 1'b1;
      if_s.s_axis_dividend_tdata  = a;
      if_s.s_axis_divisor_tvalid  = 1'b1;
      if_s.s_axis_divisor_tdata   = b;
    end
  endtask

  // Waits (bounded) for the first result pulse on the requested instances.
  // Latencies are counted in cycles from the handshake cycle, which is start_n
  // cycles before the current one; -1 means no pulse arrived in time.
  task automatic wait_result(input bit need_u, input bit need_s, input int start_n,
                             output int lat_u, output int lat_s,
                             output logic [2*W-1:0] data_u, output logic [2*W-1:0] data_s,
                             output logic user_u, output logic user_s);
    lat_u  = -1;
    lat_s  = -1;
    data_u = '0;
    data_s = '0;
    user_u = 1'b0;
    user_s = 1'b0;
    for (int n = start_n + 1; n <= start_n + BUDGET; n++) begin
      @(negedge clk);
      if (need_u && lat_u < 0 && if_u.m_axis_dout_tvalid) begin
        lat_u  = n;
        data_u = if_u.m_axis_dout_tdata;
        user_u = if_u.m_axis_dout_tuser;
      end
      if (need_s && lat_s < 0 && if_s.m_axis_dout_tvalid) begin
        lat_s  = n;
        data_s = if_s.m_axis_dout_tdata;
        user_s = if_s.m_axis_dout_tuser;
      end
      if ((!need_u || lat_u >= 0) && (!need_s || lat_s >= 0)) break;
    end
  endtask

  task automatic run_vector(input int idx);
    vec_t           v;
    int             lu;
    int             ls;
    logic [2*W-1:0] du;
    logic [2*W-1:0] ds;
    logic           uu;
    logic           us;
    v = vecs[idx];
    apply_stimulus(1'b1, 1'b1, v.a, v.b);
    check_output($sformatf("v%0d_ready", idx),
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready,
                      if_s.s_axis_dividend_tready, if_s.s_axis_divisor_tready}), 64'hF);
    @(negedge clk);
    idle_inputs();
    wait_result(1'b1, 1'b1, 1, lu, ls, du, ds, uu, us);
    check_output($sformatf("v%0d_lat_u", idx), 64'(lu), 64'(LAT));
    check_output($sformatf("v%0d_lat_s", idx), 64'(ls), 64'(LAT));
    check_output($sformatf("v%0d_data_u", idx), du, v.exp_u);
    check_output($sformatf("v%0d_data_s", idx), ds, v.exp_s);
    check_output($sformatf("v%0d_user_u", idx), 64'(uu), 64'(v.user_u));
    check_output($sformatf("v%0d_user_s", idx), 64'(us), 64'(v.user_s));
    @(negedge clk);
    check_output($sformatf("v%0d_pulse", idx),
                 64'({if_u.m_axis_dout_tvalid, if_s.m_axis_dout_tvalid}), 64'h0);
  endtask

  initial begin
    int             lu;
    int             ls;
    logic [2*W-1:0] du;
    logic [2*W-1:0] ds;
    logic           uu;
    logic           us;
    int             pu0;
    int             ps0;

    total    = 0;
    bad      = 0;
    pulses_u = 0;
    pulses_s = 0;

    //            a             b             unsigned result         u     signed result           s
    vecs[0]  = '{32'd100,      32'd7,        64'h0000000E_00000002, 1'b0, 64'h0000000E_00000002, 1'b0};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        64'h7FFFFFFC_00000001, 1'b0, 64'hFFFFFFFD_FFFFFFFF, 1'b0};
    vecs[2]  = '{32'd7,        32'hFFFFFFFE, 64'h00000000_00000007, 1'b0, 64'hFFFFFFFD_00000001, 1'b0};
    vecs[3]  = '{32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0, 64'h80000000_00000000, 1'b0};
    vecs[4]  = '{32'd5,        32'd0,        64'hFFFFFFFF_00000005, 1'b1, 64'hFFFFFFFF_00000005, 1'b1};
    vecs[5]  = '{32'hFFFFFFF9, 32'd0,        64'hFFFFFFFF_FFFFFFF9, 1'b1, 64'hFFFFFFFF_FFFFFFF9, 1'b1};
    vecs[6]  = '{32'h12345678, 32'h10,       64'h01234567_00000008, 1'b0, 64'h01234567_00000008, 1'b0};
    vecs[7]  = '{32'hFFFFFF9C, 32'hFFFFFFF9, 64'h00000000_FFFFFF9C, 1'b0, 64'h0000000E_FFFFFFFE, 1'b0};
    vecs[8]  = '{32'd0,        32'd5,        64'h00000000_00000000, 1'b0, 64'h00000000_00000000, 1'b0};
    vecs[9]  = '{32'hFFFFFFFF, 32'd1,        64'hFFFFFFFF_00000000, 1'b0, 64'hFFFFFFFF_00000000, 1'b0};
    vecs[10] = '{32'h80000000, 32'd2,        64'h40000000_00000000, 1'b0, 64'hC0000000_00000000, 1'b0};
    vecs[11] = '{32'd7,        32'd7,        64'h00000001_00000000, 1'b0, 64'h00000001_00000000, 1'b0};

    // Reset state
    rst = 1'b1;
    idle_inputs();
    repeat (3) @(negedge clk);
    check_output("rst_ready_low",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready,
                      if_s.s_axis_dividend_tready, if_s.s_axis_divisor_tready}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check_output("rst_ready_high",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready,
                      if_s.s_axis_dividend_tready, if_s.s_axis_divisor_tready}), 64'hF);
    check_output("rst_tvalid",
                 64'({if_u.m_axis_dout_tvalid, if_s.m_axis_dout_tvalid}), 64'h0);
    check_output("rst_tdata_u", if_u.m_axis_dout_tdata, 64'h0);
    check_output("rst_tdata_s", if_s.m_axis_dout_tdata, 64'h0);
    check_output("rst_tuser",
                 64'({if_u.m_axis_dout_tuser, if_s.m_axis_dout_tuser}), 64'h0);

    // Directed table on both instances
    for (int i = 0; i < NVEC; i++) run_vector(i);

    // Staggered channels on the unsigned instance; a divisor tvalid glitch that
    // never meets a clock edge must not be captured.
    if_u.s_axis_dividend_tvalid = 1'b1;
    if_u.s_axis_dividend_tdata  = 32'h12345678;
    check_output("stag_c0_ready",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready}), 64'h3);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      if (c == 1) if_u.s_axis_dividend_tvalid = 1'b0;
      check_output($sformatf("stag_c%0d_ready", c),
                   64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready}), 64'h1);
      if (c == 3) begin
        if_u.s_axis_divisor_tvalid = 1'b1;
        if_u.s_axis_divisor_tdata  = 32'hDEAD;
        #1;
        if_u.s_axis_divisor_tvalid = 1'b0;
        if_u.s_axis_divisor_tdata  = '0;
      end
    end
    @(negedge clk);
    check_output("stag_c5_ready",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready}), 64'h1);
    if_u.s_axis_divisor_tvalid = 1'b1;
    if_u.s_axis_divisor_tdata  = 32'h10;
    @(negedge clk);
    idle_inputs();
    check_output("stag_busy_ready",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready}), 64'h0);
    wait_result(1'b1, 1'b0, 6, lu, ls, du, ds, uu, us);
    check_output("stag_cycle", 64'(lu), 64'd38);
    check_output("stag_data", du, 64'h01234567_00000008);
    check_output("stag_user", 64'(uu), 64'h0);
    @(negedge clk);

    // Back-to-back: operands held valid through BUSY are taken in the DONE cycle
    pu0 = pulses_u;
    ps0 = pulses_s;
    apply_stimulus(1'b1, 1'b0, 32'd100, 32'd7);
    @(negedge clk);
    apply_stimulus(1'b1, 1'b0, 32'd9, 32'd3);
    wait_result(1'b1, 1'b0, 1, lu, ls, du, ds, uu, us);
    check_output("b2b_lat1", 64'(lu), 64'(LAT));
    check_output("b2b_data1", du, 64'h0000000E_00000002);
    check_output("b2b_done_ready",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready}), 64'h3);
    @(negedge clk);
    idle_inputs();
    check_output("b2b_pulse", 64'(if_u.m_axis_dout_tvalid), 64'h0);
    check_output("b2b_busy_ready",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready}), 64'h0);
    wait_result(1'b1, 1'b0, 1, lu, ls, du, ds, uu, us);
    check_output("b2b_lat2", 64'(lu), 64'(LAT));
    check_output("b2b_data2", du, 64'h00000003_00000000);
    repeat (40) @(negedge clk);
    check_output("b2b_pulses_u", 64'(pulses_u - pu0), 64'd2);
    check_output("b2b_pulses_s", 64'(pulses_s - ps0), 64'd0);

    // Reset at iteration 10 of a division on both instances
    apply_stimulus(1'b1, 1'b1, 32'd100, 32'd7);
    @(negedge clk);
    idle_inputs();
    repeat (10) @(negedge clk);
    pu0 = pulses_u;
    ps0 = pulses_s;
    rst = 1'b1;
    @(negedge clk);
    check_output("mid_rst_ready_low",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready,
                      if_s.s_axis_dividend_tready, if_s.s_axis_divisor_tready}), 64'h0);
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_ready_high",
                 64'({if_u.s_axis_dividend_tready, if_u.s_axis_divisor_tready,
                      if_s.s_axis_dividend_tready, if_s.s_axis_divisor_tready}), 64'hF);
    check_output("mid_rst_tdata_u", if_u.m_axis_dout_tdata, 64'h0);
    check_output("mid_rst_tdata_s", if_s.m_axis_dout_tdata, 64'h0);
    check_output("mid_rst_tuser",
                 64'({if_u.m_axis_dout_tuser, if_s.m_axis_dout_tuser}), 64'h0);
    repeat (40) @(negedge clk);
    check_output("mid_rst_no_pulse", 64'((pulses_u - pu0) + (pulses_s - ps0)), 64'd0);
    run_vector(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
